// File: rtl/sram_responder.sv
// sram_responder: arbitrates the fetch and data request ports onto one
// single-port synchronous 64-bit SRAM. Each request gets one ready pulse
// with a response code; one transaction is in flight at a time.
module sram_responder #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [63:0]           if_addr,
  input  logic [1:0]            if_size,
  output logic                  if_ready,
  output logic [1:0]            if_resp,
  output logic [63:0]           if_data_read,
  input  logic                  mem_valid,
  input  logic [63:0]           mem_addr,
  input  logic [1:0]            mem_size,
  input  logic [1:0]            mem_req,
  input  logic [63:0]           mem_data_write,
  output logic                  mem_ready,
  output logic [1:0]            mem_resp,
  output logic [63:0]           mem_data_read,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [7:0]            ram_wmask,
  output logic [63:0]           ram_wdata,
  input  logic [63:0]           ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    port_q, port_d;
  logic                    err_q, err_d;
  logic                    write_q, write_d;
  logic                    if_ready_q, if_ready_d;
  logic                    mem_ready_q, mem_ready_d;
  logic [1:0]              if_resp_q, if_resp_d;
  logic [1:0]              mem_resp_q, mem_resp_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [DEPTH_LOG2-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]              ram_wmask_q, ram_wmask_d;
  logic [63:0]             ram_wdata_q, ram_wdata_d;

  logic                    grant_valid_s;
  logic                    grant_port_s;
  logic [63:0]             sel_addr_s;
  logic [1:0]              sel_size_s;
  logic [1:0]              sel_req_s;
  logic [63:0]             sel_wdata_s;
  logic [63:0]             offset_s;
  logic                    misaligned_s;
  logic                    out_of_range_s;
  logic                    sel_err_s;
  logic [7:0]              lanes_s;
  logic [7:0]              sel_wmask_s;
  logic                    rd_ok_s;

  // Arbitration: a lone requester wins; on contention the port not served last time wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = PORT_IF;
    if (if_valid && mem_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = (last_grant_q == PORT_IF) ? PORT_MEM : PORT_IF;
    end else if (mem_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT_MEM;
    end else if (if_valid) begin
      grant_valid_s = 1'b1;
      grant_port_s  = PORT_IF;
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = PORT_IF;
    end
  end

  // Select the granted request and decode its error flag, word index and byte lanes.
  always_comb begin
    if (grant_port_s == PORT_MEM) begin
      sel_addr_s  = mem_addr;
      sel_size_s  = mem_size;
      sel_req_s   = mem_req;
      sel_wdata_s = mem_data_write;
    end else begin
      sel_addr_s  = if_addr;
      sel_size_s  = if_size;
      sel_req_s   = 2'b00;
      sel_wdata_s = 64'd0;
    end
    // Subtraction only matters when addr >= base; below-base is flagged separately
    // so the wrapped offset never masks an out-of-range access.
    offset_s       = sel_addr_s - ADDR_BASE;
    out_of_range_s = (sel_addr_s < ADDR_BASE) || ((offset_s >> (DEPTH_LOG2 + 3)) != 64'd0);
    case (sel_size_s)
      2'd0:    begin misaligned_s = 1'b0;                      lanes_s = 8'h01; end
      2'd1:    begin misaligned_s = (sel_addr_s[0]   != 1'b0); lanes_s = 8'h03; end
      2'd2:    begin misaligned_s = (sel_addr_s[1:0] != 2'b0); lanes_s = 8'h0F; end
      2'd3:    begin misaligned_s = (sel_addr_s[2:0] != 3'b0); lanes_s = 8'hFF; end
      default: begin misaligned_s = 1'b0;                      lanes_s = 8'h00; end
    endcase
    sel_wmask_s = lanes_s << sel_addr_s[2:0];
    sel_err_s   = misaligned_s || out_of_range_s || sel_req_s[1];
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    err_d        = err_q;
    write_d      = write_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;
    if_resp_d    = 2'b00;
    mem_resp_d   = 2'b00;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wmask_d  = ram_wmask_q;
    ram_wdata_d  = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d     = ACCESS;
          port_d      = grant_port_s;
          err_d       = sel_err_s;
          write_d     = (sel_req_s == 2'b01);
          ram_en_d    = !sel_err_s;
          ram_we_d    = !sel_err_s && (sel_req_s == 2'b01);
          ram_addr_d  = offset_s[DEPTH_LOG2+2:3];
          ram_wmask_d = sel_wmask_s;
          ram_wdata_d = sel_wdata_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        if_ready_d  = (port_q == PORT_IF);
        mem_ready_d = (port_q == PORT_MEM);
        if (port_q == PORT_MEM) begin
          mem_resp_d = err_q ? 2'b10 : 2'b00;
        end else begin
          if_resp_d  = err_q ? 2'b10 : 2'b00;
        end
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = port_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with all strobes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_IF;
      port_q       <= PORT_IF;
      err_q        <= 1'b0;
      write_q      <= 1'b0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_resp_q    <= 2'b00;
      mem_resp_q   <= 2'b00;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wmask_q  <= 8'h00;
      ram_wdata_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      err_q        <= err_d;
      write_q      <= write_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      if_resp_q    <= if_resp_d;
      mem_resp_q   <= mem_resp_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wmask_q  <= ram_wmask_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  // Read data arrives from the SRAM during RESP, so it is steered straight through,
  // gated by the registered ready pulse so it is zero at all other times.
  always_comb begin
    rd_ok_s = !err_q && !write_q;
    if (if_ready_q && rd_ok_s) begin
      if_data_read = ram_rdata;
    end else begin
      if_data_read = 64'd0;
    end
    if (mem_ready_q && rd_ok_s) begin
      mem_data_read = ram_rdata;
    end else begin
      mem_data_read = 64'd0;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_resp   = if_resp_q;
  assign mem_ready = mem_ready_q;
  assign mem_resp  = mem_resp_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wmask = ram_wmask_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: behavioural SRAM, expected-result queue filled
// when requests are driven and drained when a ready pulse appears.
module tb_sram_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          DL2  = 16;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic        if_ready;
  logic [1:0]  if_resp;
  logic [63:0] if_data_read;
  logic        mem_valid;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic [1:0]  mem_req;
  logic [63:0] mem_data_write;
  logic        mem_ready;
  logic [1:0]  mem_resp;
  logic [63:0] mem_data_read;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wmask;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  int checks_cnt = 0;
  int errors_cnt = 0;

  sram_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_req(mem_req), .mem_data_write(mem_data_write),
    .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM macro: one-cycle synchronous read, byte-masked write.
  logic [63:0] ram_arr [0:65535];
  logic [63:0] exp_mem [0:65535];

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  initial ram_rdata = 64'd0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_arr[ram_addr] <= merge(ram_arr[ram_addr], ram_wdata, ram_wmask);
      else        ram_rdata <= ram_arr[ram_addr];
    end
  end

  typedef struct {
    bit          port;
    logic [1:0]  resp;
    logic [63:0] data;
    int          lat;
    int          en;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] last_wmask;
  logic       last_we;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict the outcome from the request alone and the bench's own memory image.
  task automatic issue(input bit port, input logic [63:0] addr, input logic [1:0] size,
                       input logic [1:0] req, input logic [63:0] wdata, input int lat);
    exp_t        e;
    bit          err;
    logic [63:0] idx;
    int          lo;
    int          nb;
    err = 1'b0;
    if ((addr % (64'd1 << size)) != 64'd0) err = 1'b1;
    if (addr < BASE) err = 1'b1;
    else if (((addr - BASE) >> 3) >= (64'd1 << DL2)) err = 1'b1;
    if (port && req > 2'd1) err = 1'b1;
    idx = (addr - BASE) >> 3;
    e.port = port;
    e.lat  = lat;
    e.en   = err ? 0 : 1;
    e.resp = err ? 2'b10 : 2'b00;
    e.data = 64'd0;
    if (!err && port && req == 2'b01) begin
      lo = int'(addr[2:0]);
      nb = 1 << size;
      for (int b = 0; b < 8; b++)
        if (b >= lo && b < lo + nb) exp_mem[idx[15:0]][b*8 +: 8] = wdata[b*8 +: 8];
    end else if (!err) begin
      e.data = exp_mem[idx[15:0]];
    end
    exp_q.push_back(e);
    if (port) begin
      mem_addr = addr; mem_size = size; mem_req = req; mem_data_write = wdata; mem_valid = 1'b1;
    end else begin
      if_addr = addr; if_size = size; if_valid = 1'b1;
    end
  endtask

  // Collect n responses within a cycle budget; drop the served valid unless held.
  task automatic run(input int n, input bit hold);
    int   cyc;
    int   got;
    int   en_cnt;
    exp_t e;
    cyc = 0; got = 0; en_cnt = 0;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ram_en) begin
        en_cnt++;
        last_wmask = ram_wmask;
        last_we    = ram_we;
      end
      if (if_ready || mem_ready) begin
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("both_ready", 64'(if_ready && mem_ready), 64'd0);
          check_eq("port", 64'(mem_ready), 64'(e.port));
          check_eq("resp", 64'(e.port ? mem_resp : if_resp), 64'(e.resp));
          check_eq("data", e.port ? mem_data_read : if_data_read, e.data);
          check_eq("ram_en_pulses", 64'(en_cnt), 64'(e.en));
          if (e.lat > 0) check_eq("latency", 64'(cyc), 64'(e.lat));
          en_cnt = 0;
          got++;
          @(posedge clk);
          #1;
          if (!hold) begin
            if (e.port) mem_valid = 1'b0;
            else        if_valid  = 1'b0;
          end
        end
      end
    end
    check_eq("responses", 64'(got), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b0; if_valid = 1'b0; mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin ram_arr[i] = 64'd0; exp_mem[i] = 64'd0; end
    ram_arr[0] = 64'h0000_0013_0000_0093; exp_mem[0] = 64'h0000_0013_0000_0093;
    for (int i = 1; i < 4; i++) begin
      ram_arr[i] = 64'h1111_0000_0000_0000 * i + 64'(i); exp_mem[i] = ram_arr[i];
    end
    if_addr = 64'd0; if_size = 2'd0; mem_addr = 64'd0; mem_size = 2'd0;
    mem_req = 2'b00; mem_data_write = 64'd0; last_wmask = 8'h00; last_we = 1'b0;
    rst = 1'b0; if_valid = 1'b0; mem_valid = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_if_ready", 64'(if_ready), 64'd0);
    check_eq("rst_mem_ready", 64'(mem_ready), 64'd0);
    check_eq("rst_ram_en", 64'(ram_en), 64'd0);
    check_eq("rst_ram_we", 64'(ram_we), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_wmask", 64'(ram_wmask), 64'd0);
    check_eq("rst_resp", 64'({if_resp, mem_resp}), 64'd0);
    check_eq("rst_data", if_data_read | mem_data_read, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Single fetch
    issue(1'b0, BASE, 2'd2, 2'b00, 64'd0, 3);
    run(1, 1'b0);

    // Byte write then dword read
    issue(1'b1, BASE + 64'd5, 2'd0, 2'b01, 64'h0000_AB00_0000_0000, 3);
    run(1, 1'b0);
    check_eq("byte_wmask", 64'(last_wmask), 64'h20);
    check_eq("byte_we", 64'(last_we), 64'd1);
    issue(1'b1, BASE, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);
    // Half write at offset 2 checks the mask shape for a wider access
    issue(1'b1, BASE + 64'd10, 2'd1, 2'b01, 64'h0000_0000_BEEF_0000, 3);
    run(1, 1'b0);
    check_eq("half_wmask", 64'(last_wmask), 64'h0C);
    issue(1'b0, BASE + 64'd8, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);

    // Contention from reset: data port first, fetch three cycles later
    do_reset();
    issue(1'b1, BASE + 64'd16, 2'd3, 2'b00, 64'd0, 3);
    issue(1'b0, BASE, 2'd3, 2'b00, 64'd0, 6);
    run(2, 1'b0);
    // Both held: grants alternate
    issue(1'b1, BASE + 64'd24, 2'd3, 2'b00, 64'd0, 3);
    issue(1'b0, BASE + 64'd8, 2'd3, 2'b00, 64'd0, 6);
    begin
      exp_t a;
      exp_t b;
      a = exp_q[0]; a.lat = 9;  b = exp_q[1]; b.lat = 12;
      exp_q.push_back(a); exp_q.push_back(b);
    end
    run(4, 1'b1);
    if_valid = 1'b0; mem_valid = 1'b0;

    // Error cases: no RAM strobe, ERROR response, zero data
    issue(1'b0, BASE + 64'd1, 2'd1, 2'b00, 64'd0, 3);
    run(1, 1'b0);
    issue(1'b1, 64'h7FFF_FFF8, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);
    issue(1'b1, BASE + (64'd1 << (DL2 + 3)), 2'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    run(1, 1'b0);
    issue(1'b1, BASE, 2'd3, 2'b10, 64'd0, 3);
    run(1, 1'b0);
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);

    // Last word in range is legal
    issue(1'b1, BASE + (64'd1 << (DL2 + 3)) - 64'd8, 2'd3, 2'b01, 64'hCAFE_F00D_1234_5678, 3);
    run(1, 1'b0);
    issue(1'b0, BASE + (64'd1 << (DL2 + 3)) - 64'd8, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);

    // Reset during ACCESS drops the request immediately
    if_addr = BASE + 64'd8; if_size = 2'd3; if_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_ram_en", 64'(ram_en), 64'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_ram_en", 64'(ram_en), 64'd0);
    check_eq("mid_rst_ready", 64'(if_ready || mem_ready), 64'd0);
    check_eq("mid_rst_data", if_data_read, 64'd0);
    if_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    issue(1'b0, BASE, 2'd3, 2'b00, 64'd0, 3);
    run(1, 1'b0);

    // Back-to-back fetches with valid held across ready
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, BASE + 64'(k * 8), 2'd3, 2'b00, 64'd0, 3);
      run(1, (k != 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
